// File: rtl/pwm_led_array.sv
// Multi-channel PWM LED driver: per-channel static duty or a shared triangle
// breathing ramp with per-channel phase offset. Targets latch once per period.
module pwm_led_array #(
  parameter int N_CH       = 6,
  parameter int CNT_W      = 8,
  parameter int STEP_DIV   = 64,
  parameter int PHASE_OFS  = 32,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             period_start,
  output logic [N_CH-1:0]  led
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] PMAX     = CNT_W'((2 ** CNT_W) - 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [N_CH-1:0]  LED_OFF  = {N_CH{ACTIVE_LOW}};

  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [CNT_W:0]   phase;
  logic             wrap;
  logic [N_CH-1:0]  on_next;

  // Last slot of the period: the edge on which shadows load and the breath steps.
  assign wrap = en && (cnt == PMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      div          <= '0;
      phase        <= '0;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      div          <= '0;
      phase        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (wrap) begin
        cnt <= '0;
        if (div == DIV_LAST) begin
          div   <= '0;
          phase <= phase + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
    localparam logic [CNT_W:0] OFS = (CNT_W+1)'((gi * PHASE_OFS) % (2 ** (CNT_W + 1)));

    logic [CNT_W-1:0] duty_reg;
    logic [CNT_W-1:0] shd_reg;
    logic [CNT_W:0]   p;
    logic [CNT_W-1:0] tri_val;

    // Upper phase half mirrors the ramp, giving 0..max,max..0.
    assign p       = phase + OFS;
    assign tri_val = p[CNT_W] ? ~p[CNT_W-1:0] : p[CNT_W-1:0];
    assign on_next[gi] = en && (cnt < shd_reg);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_reg <= '0;
      end else if (wr_en && (wr_ch == CH_W'(gi))) begin
        duty_reg <= wr_duty;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shd_reg <= '0;
      end else if (wrap) begin
        shd_reg <= mode ? tri_val : duty_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= LED_OFF;
    end else begin
      led <= on_next ^ LED_OFF;
    end
  end

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed bench for pwm_led_array with a period/phase-level reference model
// checked every cycle, plus hand-computed on-count expectations.
module tb_pwm_led_array;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [3:0] wr_duty;
  logic       period_start;
  logic [5:0] led;

  pwm_led_array #(
    .N_CH(6), .CNT_W(4), .STEP_DIV(2), .PHASE_OFS(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_duty(wr_duty), .period_start(period_start), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: position within the 15-clock period and the number of
  // completed periods since counting (re)started; phase = periods / STEP_DIV.
  int         m_t;
  int         m_periods;
  int         m_duty [6];
  int         m_shd  [6];
  logic [5:0] exp_led;
  logic       exp_ps;

  function automatic int breath_level(input int ph);
    int q;
    q = ph % 32;
    return (q < 16) ? q : 31 - q;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t       <= 0;
      m_periods <= 0;
      for (int i = 0; i < 6; i++) begin
        m_duty[i] <= 0;
        m_shd[i]  <= 0;
      end
      exp_led <= 6'h3F;
      exp_ps  <= 1'b0;
    end else begin
      if (wr_en && int'(wr_ch) < 6) m_duty[int'(wr_ch)] <= int'(wr_duty);
      if (!en) begin
        m_t       <= 0;
        m_periods <= 0;
        exp_led   <= 6'h3F;
        exp_ps    <= 1'b0;
      end else begin
        for (int i = 0; i < 6; i++) exp_led[i] <= !(m_t < m_shd[i]);
        exp_ps <= (m_t == 14);
        if (m_t == 14) begin
          m_t       <= 0;
          m_periods <= m_periods + 1;
          for (int i = 0; i < 6; i++)
            m_shd[i] <= mode ? breath_level(m_periods / 2 + 4 * i) : m_duty[i];
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) check("cycle {led,ps}", int'({led, period_start}), int'({exp_led, exp_ps}));
  end

  // Stimulus helpers; all called on a falling edge.
  int on_cnt [6];
  int ps_mid;
  int ps_end;
  int b0 [68];
  int b1 [68];

  task automatic write(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_duty = 4'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 40);
    if (!period_start) check("ps_timeout", int'(period_start), 1);
  endtask

  // From a cnt==0 slot, count LED-on samples over the 15 following clocks.
  task automatic count_period();
    for (int i = 0; i < 6; i++) on_cnt[i] = 0;
    ps_mid = 0;
    ps_end = 0;
    for (int s = 1; s <= 15; s++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) if (led[i] == 1'b0) on_cnt[i]++;
      if (period_start) begin
        if (s == 15) ps_end++;
        else ps_mid++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_duty = '0;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset led", int'(led), 'h3F);
    check("reset ps", int'(period_start), 0);
    @(negedge clk);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    en     = 1'b1;

    // Static duties.
    write(0, 5);
    write(5, 15);
    write(3, 0);
    wait_ps();
    count_period();
    check("static ch0", on_cnt[0], 5);
    check("static ch5", on_cnt[5], 15);
    check("static ch3", on_cnt[3], 0);
    check("ps mid-period", ps_mid, 0);
    check("ps at 15 clocks", ps_end, 1);

    // Mid-period write keeps the running period.
    fork
      count_period();
      begin
        repeat (7) @(negedge clk);
        write(0, 10);
      end
    join
    check("midwrite same period", on_cnt[0], 5);
    count_period();
    check("midwrite next period", on_cnt[0], 10);

    // Write on the wrap edge applies one period later.
    repeat (14) @(negedge clk);
    write(0, 3);
    count_period();
    check("wrapwrite period+0", on_cnt[0], 10);
    count_period();
    check("wrapwrite period+1", on_cnt[0], 3);

    // Out-of-range channel writes are ignored.
    write(6, 9);
    write(7, 9);
    wait_ps();
    count_period();
    check("invalid ch0", on_cnt[0], 3);
    check("invalid ch1", on_cnt[1], 0);
    check("invalid ch5", on_cnt[5], 15);

    // Breathing from a fresh phase 0.
    en   = 1'b0;
    mode = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_ps();
    for (int k = 0; k < 68; k++) begin
      count_period();
      b0[k] = on_cnt[0];
      b1[k] = on_cnt[1];
    end
    check("breath ch0 p0", b0[0], 0);
    check("breath ch0 p1", b0[1], 0);
    check("breath ch0 p2", b0[2], 1);
    check("breath ch0 p30", b0[30], 15);
    check("breath ch0 p33", b0[33], 15);
    check("breath ch0 p34", b0[34], 14);
    check("breath ch0 p63", b0[63], 0);
    check("breath ch0 p64 wrap", b0[64], 0);
    check("breath ch0 p66 wrap", b0[66], 1);
    check("breath ch1 p0", b1[0], 4);
    check("breath ch1 p24", b1[24], 15);
    check("breath ch1 p62", b1[62], 3);

    // en toggle mid-period: LEDs go inactive, duties survive.
    repeat (5) @(negedge clk);
    en   = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    check("en low led", int'(led), 'h3F);
    check("en low ps", int'(period_start), 0);
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_ps();
    count_period();
    check("resume ch0", on_cnt[0], 3);
    check("resume ch5", on_cnt[5], 15);
    check("resume ch3", on_cnt[3], 0);

    // Reset mid-operation clears everything, including duties.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst led", int'(led), 'h3F);
    check("midrst ps", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps();
    count_period();
    check("post-reset ch5", on_cnt[5], 0);
    check("post-reset ch0", on_cnt[0], 0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_led_array.md
Name: pwm_led_array

Overview:
Parametrised multi-channel PWM LED driver. It is the successor to the single-pattern pwm_led block. Each of N_CH channels has its own programmable duty cycle (static mode). A shared triangle "breathing" generator with a per-channel phase offset covers breath mode. It sits between the control logic (duty writes, mode select) and the board LED pins, and drives them directly.

Parameters:
N_CH, 6, number of LED channels (1..32)
CNT_W, 8, PWM resolution in bits; period = 2^CNT_W-1 clocks
STEP_DIV, 64, PWM periods per breathing phase step (>=1)
PHASE_OFS, 32, breathing phase offset between adjacent channels, modulo 2^(CNT_W+1)
ACTIVE_LOW, 1, 1: LED on = 0 on the pin; 0: LED on = 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock domain, asynchronous assert, active-low
en  in  1  1: run; 0: counters held at 0, all LEDs inactive
mode  in  1  0: static per-channel duty; 1: breathing
wr_en  in  1  duty write strobe, one-cycle
wr_ch  in  max(1,$clog2(N_CH))  channel index for the write
wr_duty  in  CNT_W  duty value for the write
period_start  out  1  one-cycle pulse coincident with cnt==0
led  out  N_CH  LED pin drive, registered

Behaviour:
- Reset (rst_n=0, asynchronous): cnt=0, div=0, phase=0, all duty and shadow registers=0, period_start=0, led=all inactive (ACTIVE_LOW ? all ones : all zeros). The outputs take these values immediately, with no clock edge needed.
- PWM counter cnt (CNT_W bits) counts 0..PMAX, where PMAX=2^CNT_W-2, then wraps to 0. The period is therefore 2^CNT_W-1 clocks.
- Duty registers: wr_en=1 with wr_ch<N_CH writes duty[wr_ch]<=wr_duty on that edge. wr_ch>=N_CH is ignored. Writes are accepted in either mode, and while en=0.
- Target duty per channel: tgt[i] = duty[i] in static mode, or tri[i] in breath mode.
- Shadow: on the edge where cnt==PMAX, shd[i]<=tgt[i]. Duty changes, mode changes and phase steps therefore never take effect mid-period. This gives glitch-free output.
- Compare: each edge, on_i <= (cnt < shd[i]); led[i] <= on_i XOR ACTIVE_LOW. The LED level for slot k appears one clock after cnt==k.
- Duty boundaries: shd=0 means never on. shd=2^CNT_W-1 means always on. Any shd=d gives exactly d on-cycles per period.
- period_start is registered: it is 1 for the clock after cnt==PMAX wraps, aligned with the cnt==0 slot.
- Breath generator:
  - div counts PWM periods 0..STEP_DIV-1.
  - On the edge where cnt==PMAX and div==STEP_DIV-1, phase (CNT_W+1 bits) <= phase+1 (wraps) and div<=0. At any other edge with cnt==PMAX, div<=div+1.
  - Per channel: p_i = phase + i*PHASE_OFS (mod 2^(CNT_W+1)); tri[i] = p_i[CNT_W] ? ~p_i[CNT_W-1:0] : p_i[CNT_W-1:0].
  - The resulting ramp is 0,1,...,max,max,...,1,0.
  - The phase step and the shadow load happen on the same edge; the shadow takes the pre-step tri.
- en=0 (synchronous): cnt, div and phase held at 0; on_i=0; led inactive; period_start=0; duty registers retained. After en returns to 1, counting starts at cnt=0 on the next edge. Shadow values are those loaded before en went low, or 0 after reset. New targets apply from the first cnt==PMAX edge.
- Simultaneous events:
  - A write on the cnt==PMAX edge updates duty only. The shadow takes the old duty, so the new value applies one period later.
  - A mode change on the cnt==PMAX edge is visible in the shadow load of that same edge (mode is sampled combinationally).
- Reset mid-operation: all state is cleared as above; there are no partial periods after release.

Test Plan:
(All with N_CH=6, CNT_W=4 (period 15, PMAX 14), STEP_DIV=2, PHASE_OFS=4, ACTIVE_LOW=1.)
1. Reset: hold rst_n=0, then drop rst_n between clock edges while running -> led=6'h3F and period_start=0 immediately, before the next edge. After release with en=1, period_start pulses every 15 clocks.
2. Static duty: mode=0, write ch0=5, ch5=15, ch3=0 -> from the second period onward, per 15-clock period led[0] is low for exactly 5 clocks (slots 0-4, each one clock later), led[5] is always low, and led[3] is always high.
3. Mid-period write: during slot 7, write ch0 5->10 -> the current period keeps 5 on-clocks and the next period has 10. A write on the slot-14 edge applies one period later.
4. Invalid channel: write wr_ch=6 or 7 -> no duty register changes, and led patterns are unchanged.
5. Breath: mode=1 -> phase steps every 30 clocks. The ch0 on-count per period follows shadow loads of 0,0,1,1,...,15,15,15,15,14,14,... The ch1 sequence is the ch0 sequence advanced by 4 phase steps. Check a full 32-step phase wrap.
6. en toggle: en=0 mid-period -> led=6'h3F on the next edge with duty registers retained. en=1 -> cnt restarts at 0, and the static pattern from scenario 2 resumes.
